// File: rtl/rs_age_cdb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_age_cdb_pkg
//  Description : Shared configuration for the age-ordered reservation
//                station: RoB tag width, default depth and the instruction
//                type codes the Decoder forwards to this station.
//  Revision    : 1.0  initial release
// ============================================================================
package rs_age_cdb_pkg;

  // Width of a RoB tag (16-entry reorder buffer)
  localparam int ROB_SIZE_WIDTH = 4;

  // Default reservation-station depth
  localparam int RS_SIZE = 8;

  // Instruction type codes (RISC-V major opcodes) routed to the integer path
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] B_TYPE = 7'b1100011;

endpackage
`default_nettype wire

// File: rtl/rs_age_cdb_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rs_age_picker
//  Description : DEPTH x DEPTH age matrix. older_q[r][c] = 1 means entry r
//                was allocated before entry c. Keeps the matrix up to date
//                from one-hot alloc/free vectors and reports the oldest
//                requesting entry as one-hot and binary index.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_age_picker
  import rs_age_cdb_pkg::*;
#(
  parameter int DEPTH = RS_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [DEPTH-1:0]         alloc,
  input  logic [DEPTH-1:0]         free,
  input  logic [DEPTH-1:0]         req,
  output logic [DEPTH-1:0]         grant,
  output logic [$clog2(DEPTH)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  // Matrix update: a freed entry loses all relations; a new entry is younger
  // than every other slot (stale bits of idle slots are masked by req).
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < DEPTH; c++) begin
        if (free[r] || free[c]) begin
          older_d[r][c] = 1'b0;
        end else if (alloc[r]) begin
          older_d[r][c] = 1'b0;
        end else if (alloc[c]) begin
          older_d[r][c] = (r != c);
        end else begin
          older_d[r][c] = older_q[r][c];
        end
      end
    end
  end

  // Age matrix register, wiped by reset or flush
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int r = 0; r < DEPTH; r++) begin
        older_q[r] <= '0;
      end
    end else begin
      older_q <= older_d;
    end
  end

  // An entry wins when no other requester is older than it
  always_comb begin
    logic blk;
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blk = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (req[j] && older_q[j][i]) begin
          blk = 1'b1;
        end
      end
      grant[i] = req[i] && !blk;
    end
  end

  // One-hot to binary; index 0 when nothing is granted
  always_comb begin
    grant_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (grant[i]) begin
        grant_idx = i[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_age_cdb.sv
`default_nettype none
// ============================================================================
//  Module      : rs_age_cdb
//  Description : Integer/branch reservation station with NUM_CDB broadcast
//                wakeup channels, enqueue-time CDB bypass and oldest-ready
//                issue through a valid/ready handshake to an external ALU.
//                Optional macro RS_WAKEUP_BYPASS_EN: an entry whose last
//                pending operand is broadcast this cycle may issue in the
//                same cycle with the operand forwarded from the CDB.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_age_cdb
  import rs_age_cdb_pkg::*;
#(
  parameter int DEPTH   = RS_SIZE,
  parameter int NUM_CDB = 2,
  parameter int ROB_W   = ROB_SIZE_WIDTH,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        rob_clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_op,
  input  logic [6:0]                  in_type,
  input  logic                        in_op_other,
  input  logic [DATA_W-1:0]           in_v1,
  input  logic [DATA_W-1:0]           in_v2,
  input  logic                        in_dep1,
  input  logic                        in_dep2,
  input  logic [ROB_W-1:0]            in_q1,
  input  logic [ROB_W-1:0]            in_q2,
  input  logic [ROB_W-1:0]            in_rob_id,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]    cdb_rob_id,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_value,
  output logic                        ex_valid,
  input  logic                        ex_ready,
  output logic [2:0]                  ex_op,
  output logic [6:0]                  ex_type,
  output logic                        ex_op_other,
  output logic [DATA_W-1:0]           ex_v1,
  output logic [DATA_W-1:0]           ex_v2,
  output logic [ROB_W-1:0]            ex_rob_id,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry state
  logic [DEPTH-1:0]  busy_q, busy_d, dep1_q, dep1_d, dep2_q, dep2_d;
  logic [DATA_W-1:0] v1_q [DEPTH], v1_d [DEPTH], v2_q [DEPTH], v2_d [DEPTH];
  logic [ROB_W-1:0]  q1_q [DEPTH], q1_d [DEPTH], q2_q [DEPTH], q2_d [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH], rob_d [DEPTH];
  logic [2:0]        op_q [DEPTH], op_d [DEPTH];
  logic [6:0]        typ_q [DEPTH], typ_d [DEPTH];
  logic [DEPTH-1:0]  oth_q, oth_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Unpacked broadcast channels
  logic [ROB_W-1:0]  w_cdb_tag [NUM_CDB];
  logic [DATA_W-1:0] w_cdb_val [NUM_CDB];

  for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb
    assign w_cdb_tag[k] = cdb_rob_id[k*ROB_W +: ROB_W];
    assign w_cdb_val[k] = cdb_value[k*DATA_W +: DATA_W];
  end

  // Tag matches against the CDB; descending scan so the lowest channel wins
  logic [DEPTH-1:0]  w_hit1, w_hit2;
  logic [DATA_W-1:0] w_hv1 [DEPTH], w_hv2 [DEPTH];
  logic              w_in_hit1, w_in_hit2;
  logic [DATA_W-1:0] w_in_hv1, w_in_hv2;

  // CDB lookup for every stored operand tag and for the incoming tags
  always_comb begin
    w_in_hit1 = 1'b0;
    w_in_hit2 = 1'b0;
    w_in_hv1  = '0;
    w_in_hv2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1[i] = 1'b0;
      w_hit2[i] = 1'b0;
      w_hv1[i]  = '0;
      w_hv2[i]  = '0;
    end
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_cdb_tag[k] == q1_q[i]) begin
            w_hit1[i] = 1'b1;
            w_hv1[i]  = w_cdb_val[k];
          end
          if (w_cdb_tag[k] == q2_q[i]) begin
            w_hit2[i] = 1'b1;
            w_hv2[i]  = w_cdb_val[k];
          end
        end
        if (w_cdb_tag[k] == in_q1) begin
          w_in_hit1 = 1'b1;
          w_in_hv1  = w_cdb_val[k];
        end
        if (w_cdb_tag[k] == in_q2) begin
          w_in_hit2 = 1'b1;
          w_in_hv2  = w_cdb_val[k];
        end
      end
    end
  end

  // Issue eligibility and the operand values presented on ex_*
  logic [DEPTH-1:0]  w_req;
  logic [DATA_W-1:0] w_fv1 [DEPTH], w_fv2 [DEPTH];

  // Ready vector; with same-cycle bypass a pending operand counts as
  // satisfied when its tag is on the CDB right now
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
      w_req[i] = busy_q[i] && !(dep1_q[i] && !w_hit1[i]) && !(dep2_q[i] && !w_hit2[i]);
      w_fv1[i] = dep1_q[i] ? w_hv1[i] : v1_q[i];
      w_fv2[i] = dep2_q[i] ? w_hv2[i] : v2_q[i];
`else
      w_req[i] = busy_q[i] && !dep1_q[i] && !dep2_q[i];
      w_fv1[i] = v1_q[i];
      w_fv2[i] = v2_q[i];
`endif
    end
  end

  logic [DEPTH-1:0] w_grant, w_alloc_vec, w_free_vec;
  logic [IDX_W-1:0] w_sel_idx, w_alloc_idx;
  logic             w_enq, w_deq;

  assign in_ready = rdy && (count_q != FULL_CNT);
  assign ex_valid = rdy && (|w_req);
  assign w_enq    = in_valid && in_ready;
  assign w_deq    = ex_valid && ex_ready;

  // Lowest-index free slot; a slot being dequeued is still busy here, so
  // it can never be reallocated in the same cycle
  always_comb begin
    w_alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        w_alloc_idx = i[IDX_W-1:0];
      end
    end
  end

  assign w_alloc_vec = w_enq ? ({{(DEPTH-1){1'b0}}, 1'b1} << w_alloc_idx) : '0;
  assign w_free_vec  = w_deq ? w_grant : '0;

  rs_age_picker #(
    .DEPTH (DEPTH)
  ) u_picker (
    .clk       (clk),
    .rst       (rst),
    .clear     (rob_clear),
    .alloc     (w_alloc_vec),
    .free      (w_free_vec),
    .req       (w_req),
    .grant     (w_grant),
    .grant_idx (w_sel_idx)
  );

  // Selected entry drives the ALU interface (index 0 when empty)
  assign ex_op       = op_q[w_sel_idx];
  assign ex_type     = typ_q[w_sel_idx];
  assign ex_op_other = oth_q[w_sel_idx];
  assign ex_v1       = w_fv1[w_sel_idx];
  assign ex_v2       = w_fv2[w_sel_idx];
  assign ex_rob_id   = rob_q[w_sel_idx];
  assign count       = count_q;

  // Next state: wakeup, dequeue and enqueue, all frozen while rdy is low
  always_comb begin
    busy_d  = busy_q;
    dep1_d  = dep1_q;
    dep2_d  = dep2_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    q1_d    = q1_q;
    q2_d    = q2_q;
    rob_d   = rob_q;
    op_d    = op_q;
    typ_d   = typ_q;
    oth_d   = oth_q;
    count_d = count_q;
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && dep1_q[i] && w_hit1[i]) begin
          dep1_d[i] = 1'b0;
          v1_d[i]   = w_hv1[i];
        end
        if (busy_q[i] && dep2_q[i] && w_hit2[i]) begin
          dep2_d[i] = 1'b0;
          v2_d[i]   = w_hv2[i];
        end
      end
      if (w_deq) begin
        busy_d[w_sel_idx] = 1'b0;
      end
      if (w_enq) begin
        busy_d[w_alloc_idx] = 1'b1;
        dep1_d[w_alloc_idx] = in_dep1 && !w_in_hit1;
        dep2_d[w_alloc_idx] = in_dep2 && !w_in_hit2;
        v1_d[w_alloc_idx]   = (in_dep1 && w_in_hit1) ? w_in_hv1 : in_v1;
        v2_d[w_alloc_idx]   = (in_dep2 && w_in_hit2) ? w_in_hv2 : in_v2;
        q1_d[w_alloc_idx]   = in_q1;
        q2_d[w_alloc_idx]   = in_q2;
        rob_d[w_alloc_idx]  = in_rob_id;
        op_d[w_alloc_idx]   = in_op;
        typ_d[w_alloc_idx]  = in_type;
        oth_d[w_alloc_idx]  = in_op_other;
      end
      case ({w_enq, w_deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: cleared by reset or flush regardless of rdy
  always_ff @(posedge clk) begin
    if (rst || rob_clear) begin
      busy_q  <= '0;
      dep1_q  <= '0;
      dep2_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      dep1_q  <= dep1_d;
      dep2_q  <= dep2_d;
      count_q <= count_d;
    end
  end

  // Payload storage; only meaningful while the entry is busy
  always_ff @(posedge clk) begin
    v1_q  <= v1_d;
    v2_q  <= v2_d;
    q1_q  <= q1_d;
    q2_q  <= q2_d;
    rob_q <= rob_d;
    op_q  <= op_d;
    typ_q <= typ_d;
    oth_q <= oth_d;
  end

endmodule
`default_nettype wire
